// File: rtl/max7219_pkg.sv
// max7219_pkg: shared state encoding, register addresses and word packing for the MAX7219 chain controller
package max7219_pkg;

    typedef enum logic [2:0] {TEST, DECODE, SCAN, INTENS, WAKE, DIGIT, INT_UPD} state_t;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCAN      = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] value);
        return {4'h0, addr, value};
    endfunction

endpackage

// File: rtl/max7219_chain_controller_frame_builder.sv
// max7219_frame_builder: combinational chain-frame assembly for one sequencer state
//   state/digit : frame being loaded next
//   live/shadow : framebuffer now and as snapshotted at the start of the sweep
//   intensity   : value used by INTENS and INT_UPD frames
//   frame       : one 16-bit word per device, device 0 in the low bits
module max7219_frame_builder
    import max7219_pkg::*;
#(
    parameter int         NUM_DEVICES = 4,
    parameter int         NUM_DIGITS  = 8,
    parameter logic [7:0] DECODE_MODE = 8'h00
) (
    input  state_t                       state,
    input  logic [3:0]                   digit,
    input  logic [64*NUM_DEVICES-1:0]    live,
    input  logic [64*NUM_DEVICES-1:0]    shadow,
    input  logic [3:0]                   intensity,
    output logic [16*NUM_DEVICES-1:0]    frame
);
    logic [3:0]                  addr;
    logic [7:0]                  value;
    logic [2:0]                  sel;
    logic [64*NUM_DEVICES-1:0]   src;

    always_comb begin
        sel   = 3'(digit - 4'd1);
        // digit 1 is loaded on the same edge that takes the snapshot, so it reads the live buffer
        src   = (digit == 4'd1) ? live : shadow;
        addr  = state == TEST   ? REG_TEST :
                state == DECODE ? REG_DECODE :
                state == SCAN   ? REG_SCAN :
                state == WAKE   ? REG_SHUTDOWN :
                state == DIGIT  ? digit : REG_INTENSITY;
        value = state == TEST   ? 8'h00 :
                state == DECODE ? DECODE_MODE :
                state == SCAN   ? 8'(NUM_DIGITS - 1) :
                state == WAKE   ? 8'h01 : {4'h0, intensity};
        frame = '0;
        for (int k = 0; k < NUM_DEVICES; k++)
            frame[16*k +: 16] = make_word(addr, state == DIGIT ? src[64*k + 8*sel +: 8] : value);
    end
endmodule

// File: rtl/max7219_chain_controller.sv
// max7219_chain_controller: init + continuous digit refresh sequencer for a MAX7219 daisy chain
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   in_data                 : framebuffer, 64 bits per device, digit d of device k at [64k+8(d-1) +: 8]
//   in_intensity, in_reinit : requested brightness, single-cycle re-init request
//   out_data/valid/ack      : registered chain frame handshake, one frame per ack
//   init_done, sweep_done   : init complete level, end-of-sweep pulse
module max7219_chain_controller
    import max7219_pkg::*;
#(
    parameter int         NUM_DEVICES = 4,
    parameter int         NUM_DIGITS  = 8,
    parameter logic [7:0] DECODE_MODE = 8'h00
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [64*NUM_DEVICES-1:0]    in_data,
    input  logic [3:0]                   in_intensity,
    input  logic                         in_reinit,
    output logic [16*NUM_DEVICES-1:0]    out_data,
    output logic                         out_valid,
    input  logic                         out_ack,
    output logic                         init_done,
    output logic                         sweep_done
);
    localparam logic [3:0] LAST = 4'(NUM_DIGITS);

    state_t                      state, nxt_state;
    logic [3:0]                  digit, nxt_digit, wrap_digit, applied;
    logic [64*NUM_DEVICES-1:0]   shadow;
    logic [16*NUM_DEVICES-1:0]   frame;
    logic                        pend_int, pend_reinit, reinit_req, load, acked;

    assign reinit_req = pend_reinit | in_reinit;
    assign acked      = out_valid & out_ack;
    // the very first frame after reset is loaded without waiting for an ack
    assign load       = !out_valid | out_ack;
    assign wrap_digit = digit == LAST ? 4'd1 : digit + 4'd1;

    always_comb begin
        nxt_state = state;
        nxt_digit = digit;
        if (acked) begin
            if (reinit_req)
                nxt_state = TEST;
            else
                case (state)
                    TEST:    nxt_state = DECODE;
                    DECODE:  nxt_state = SCAN;
                    SCAN:    nxt_state = INTENS;
                    INTENS:  nxt_state = WAKE;
                    WAKE:    begin nxt_state = DIGIT; nxt_digit = 4'd1; end
                    DIGIT:   if (pend_int) nxt_state = INT_UPD; else nxt_digit = wrap_digit;
                    default: begin nxt_state = DIGIT; nxt_digit = wrap_digit; end
                endcase
        end
    end

    max7219_frame_builder #(
        .NUM_DEVICES (NUM_DEVICES),
        .NUM_DIGITS  (NUM_DIGITS),
        .DECODE_MODE (DECODE_MODE)
    ) u_builder (
        .state     (nxt_state),
        .digit     (nxt_digit),
        .live      (in_data),
        .shadow    (shadow),
        .intensity (in_intensity),
        .frame     (frame)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= TEST;
            digit       <= 4'd1;
            applied     <= 4'hF;
            shadow      <= '0;
            pend_int    <= 1'b0;
            pend_reinit <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            init_done   <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            sweep_done  <= acked && state == DIGIT && digit == LAST;
            init_done   <= reinit_req ? 1'b0 : (acked && state == WAKE) ? 1'b1 : init_done;
            pend_reinit <= (load && nxt_state == TEST) ? 1'b0 : reinit_req;
            // re-init replays INTENS, so it supersedes any pending intensity update
            pend_int    <= (reinit_req || (load && nxt_state == INT_UPD)) ? 1'b0 :
                           (init_done && in_intensity != applied) ? 1'b1 : pend_int;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= frame;
                state     <= nxt_state;
                digit     <= nxt_digit;
                if (nxt_state == INTENS || nxt_state == INT_UPD)
                    applied <= in_intensity;
                if (nxt_state == DIGIT && nxt_digit == 4'd1)
                    shadow <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_max7219_chain_controller.sv
// tb_max7219_chain_controller: randomized handshake bench with a frame-level reference model
module tb_max7219_chain_controller;
    localparam int         ND = 2;
    localparam int         NG = 8;
    localparam logic [7:0] DM = 8'h00;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [64*ND-1:0]  in_data = '0;
    logic [3:0]        in_intensity = 4'hF;
    logic              in_reinit = 1'b0;
    logic              out_ack = 1'b0;
    logic [16*ND-1:0]  out_data;
    logic              out_valid, init_done, sweep_done;

    always #5 clock = ~clock;

    max7219_chain_controller #(.NUM_DEVICES(ND), .NUM_DIGITS(NG), .DECODE_MODE(DM)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_intensity (in_intensity),
        .in_reinit    (in_reinit),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .init_done    (init_done),
        .sweep_done   (sweep_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: frames as a queue of init register writes followed by digit sweeps
    bit                m_valid, m_init, m_sweep, m_pint, m_preinit, m_clr;
    logic [3:0]        m_applied;
    int                m_digit, m_addr;
    logic [64*ND-1:0]  m_shadow;
    logic [16*ND-1:0]  m_data;
    int                iq[$];

    function automatic logic [16*ND-1:0] rep(input int addr, input logic [7:0] v);
        logic [16*ND-1:0] r;
        for (int k = 0; k < ND; k++) r[16*k +: 16] = {4'h0, 4'(addr), v};
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_init = 0; m_sweep = 0; m_pint = 0; m_preinit = 0;
        m_applied = 4'hF; m_digit = NG; m_addr = 0; m_data = '0;
        iq = '{15, 9, 11, 10, 12};
    endtask

    task automatic advance();
        int a;
        logic [7:0] v;
        if (m_valid && m_addr == NG) m_sweep = 1;
        if (m_valid && m_addr == 12 && !m_preinit) m_init = 1;
        if (m_preinit) begin
            iq = '{15, 9, 11, 10, 12};
            m_preinit = 0; m_pint = 0; m_init = 0; m_digit = NG; m_clr = 1;
        end
        if (iq.size() != 0) begin
            a = iq.pop_front();
            v = a == 15 ? 8'h00 : a == 9 ? DM : a == 11 ? 8'(NG - 1) : a == 10 ? {4'h0, in_intensity} : 8'h01;
            if (a == 10) m_applied = in_intensity;
            m_addr = a;
            m_data = rep(a, v);
        end else if (m_pint && m_addr >= 1 && m_addr <= NG) begin
            m_pint = 0; m_clr = 1;
            m_applied = in_intensity;
            m_addr = 10;
            m_data = rep(10, {4'h0, in_intensity});
        end else begin
            m_digit = m_digit % NG + 1;
            if (m_digit == 1) m_shadow = in_data;
            m_addr = m_digit;
            for (int k = 0; k < ND; k++)
                m_data[16*k +: 16] = {4'h0, 4'(m_digit), m_shadow[64*k + 8*(m_digit-1) +: 8]};
        end
        m_valid = 1;
    endtask

    task automatic cyc(input bit ack);
        bit pre;
        out_ack = ack;
        @(posedge clock);
        #1;
        pre = m_init && (in_intensity != m_applied);
        m_sweep = 0; m_clr = 0;
        if (in_reinit) begin m_preinit = 1; m_init = 0; end
        if (!m_valid || ack) advance();
        if (m_preinit) m_pint = 0;
        else if (pre && !m_clr) m_pint = 1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("init_done", 64'(init_done), 64'(m_init));
        check("sweep_done", 64'(sweep_done), 64'(m_sweep));
        in_reinit = 1'b0;
    endtask

    task automatic rnd(input int n);
        repeat (n) begin
            if ($urandom % 2 == 1) in_data = {$urandom, $urandom, $urandom, $urandom};
            cyc($urandom % 4 != 0);
        end
    endtask

    task automatic wait_addr(input int target);
        int i;
        for (i = 0; i < 200 && m_addr != target; i++) cyc($urandom % 4 != 0);
        if (i == 200) check("wait_timeout", 64'(m_addr), 64'(target));
    endtask

    logic [31:0] init_exp [5] = '{32'h0F000F00, 32'h09000900, 32'h0B070B07, 32'h0A0F0A0F, 32'h0C010C01};

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_init", 64'(init_done), 64'd0);
        check("rst_sweep", 64'(sweep_done), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("init_seq", 64'(out_data), 64'(init_exp[i]));
        end
        repeat (NG) cyc(1);
        rnd(300);

        wait_addr(4);
        repeat (10) cyc(0);
        cyc(1);
        check("hold_advance", 64'(out_data[15:8]), 64'h05);

        wait_addr(NG);
        in_data = '0;
        in_data[7:0] = 8'hA5;
        in_data[71:64] = 8'h3C;
        cyc(1);
        check("digit1_frame", 64'(out_data), 64'h013C01A5);
        repeat (3) cyc(1);
        in_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (6) cyc(1);

        wait_addr(3);
        in_intensity = 4'h3;
        repeat (3) cyc(0);
        cyc(1);
        check("int_upd", 64'(out_data), 64'h0A030A03);
        cyc(1);
        check("int_resume", 64'(out_data[15:8]), 64'h04);
        rnd(40);

        wait_addr(6);
        in_reinit = 1'b1;
        cyc(0);
        check("reinit_init_low", 64'(init_done), 64'd0);
        repeat (4) cyc(0);
        check("reinit_hold", 64'(out_data[15:8]), 64'h06);
        cyc(1);
        check("reinit_test", 64'(out_data), 64'h0F000F00);
        rnd(100);

        wait_addr(2);
        in_intensity = 4'($urandom_range(0, 14));
        repeat (2) cyc(0);
        rnd(100);

        wait_addr(5);
        out_ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_data", 64'(out_data), 64'd0);
        check("async_init", 64'(init_done), 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(1);
        check("post_reset", 64'(out_data), 64'h0F000F00);
        rnd(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/max7219_chain_controller.md
Name: max7219_chain_controller

Overview:
- Frame sequencer for a daisy-chain of MAX7219 LED drivers. It is the parametrised successor of the single-device register walker.
- Issues a power-up init sequence, then continuously refreshes the digit registers of NUM_DEVICES chained devices.
- Inserts intensity updates on demand and supports a re-init request.
- Sits between the display framebuffer and the SPI shifter; one output word is one LOAD-framed chain write.

Parameters:
- NUM_DEVICES, 4, number of chained MAX7219s (1..8).
- NUM_DIGITS, 8, digits refreshed per device (1..8). Scan-limit register value is NUM_DIGITS-1.
- DECODE_MODE, 8'h00, value written to the decode-mode register.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  64*NUM_DEVICES  framebuffer. Device k digit d (1-based) = in_data[64k+8(d-1)+7 : 64k+8(d-1)].
- in_intensity  in  4  requested intensity, 0..15
- in_reinit  in  1  single-cycle pulse: rerun init sequence
- out_data  out  16*NUM_DEVICES  chain frame, shifted MSB first. Top 16 bits go to device NUM_DEVICES-1; bits [15:0] go to device 0.
- out_valid  out  1  frame valid
- out_ack  in  1  consumer accepted frame this cycle (meaningful only when out_valid=1)
- init_done  out  1  high once init sequence completes, low during (re)init
- sweep_done  out  1  one-cycle pulse when digit NUM_DIGITS frame is acked

Behaviour:
- Every per-device 16-bit word is {4'h0, addr[3:0], value[7:0]}. All devices in a frame share the same addr; values differ only for digit frames.
- Reset (reset_n=0, async):
  - out_valid=0, out_data=0, init_done=0, sweep_done=0.
  - State=TEST, applied intensity=in_intensity's reset image 4'hF, pending flags cleared.
- First rising edge after reset release loads the TEST frame and sets out_valid=1.
- From then on out_valid stays 1. out_data is registered and held stable while out_valid && !out_ack.
- Next frame is loaded on the same edge that samples out_ack=1: zero-bubble, one frame per ack.
- State sequence, each advance on ack:
  - TEST (addr F, val 0)
  - DECODE (addr 9, DECODE_MODE)
  - SCAN (addr B, NUM_DIGITS-1)
  - INTENS (addr A, in_intensity sampled at frame load)
  - WAKE (addr C, val 1)
  - DIGIT
  - init_done rises on the ack of WAKE.
- DIGIT: digit counter runs 1..NUM_DIGITS, then wraps to 1.
  - in_data is snapshotted into a shadow register when the digit-1 frame is loaded, so a sweep is tear-free.
  - Frames for digits 2..N use the shadow.
  - sweep_done pulses on the ack of digit NUM_DIGITS.
- Intensity update:
  - If in_intensity != applied intensity while init_done=1, set pending.
  - On the next DIGIT ack, go to INT_UPD (addr A, new value) instead of the next digit. Applied intensity updates when INT_UPD is loaded.
  - After the INT_UPD ack, resume at the interrupted digit+1 with the same wrap rule.
  - A change during INT_UPD re-sets pending; it is serviced after the next digit.
- Re-init:
  - in_reinit latches a pending flag; init_done clears immediately.
  - The current frame is never truncated: on its ack go to TEST.
  - Re-init wins over a pending intensity update and clears it, since INTENS covers it.
- No-op frames (addr 0) are never generated.
- reset_n asserted mid-frame: outputs drop to reset values immediately; the sequence restarts at TEST.

Decomposition:
- Package max7219_pkg:
  - typedef enum state_t {TEST, DECODE, SCAN, INTENS, WAKE, DIGIT, INT_UPD}
  - register address localparams REG_NOOP..REG_TEST
  - function make_word(addr, value) returning the 16-bit word
- Sub-module max7219_frame_builder (combinational): replicates/selects per-device words from state, digit index and shadow buffer. This keeps the sequencer FSM small.

Test Plan:
- Reset, out_ack tied 1, NUM_DEVICES=2, NUM_DIGITS=8, DECODE_MODE=0 -> out_data sequence 32'h0F000F00, 32'h09000900, 32'h0B070B07, 32'h0A0F0A0F, 32'h0C010C01. init_done rises after 5th ack; then digit frames 1..8.
- Hold out_ack=0 for 10 cycles mid-sweep -> out_data and out_valid unchanged throughout; advances exactly once when ack pulses.
- in_data device0 digit1=8'hA5, device1 digit1=8'h3C -> digit-1 frame = 32'h013C01A5. Changing in_data at digit 4 does not affect digits 5..8 until the next sweep.
- in_intensity 15->3 during digit-3 frame -> after digit-3 ack next frame is 32'h0A030A03, then digit 4. No second INT_UPD.
- in_reinit pulse while out_ack=0 on digit 6 -> init_done falls next cycle; digit-6 frame held until ack, then TEST frame. Full init replays.
- Assert reset_n low while out_valid=1 and ack pending -> out_valid=0 asynchronously; after release, first frame is TEST.
